// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control encodings: EX jump types (also used by DataForwarding)
// and the hazard sequencer FSM states.
package pipe_ctrl_pkg;

    localparam logic [1:0] NO_JUMP = 2'b00;
    localparam logic [1:0] JAL     = 2'b01;
    localparam logic [1:0] JAL_R   = 2'b10;

    typedef enum logic [1:0] {
        INIT     = 2'b00,
        RUN      = 2'b01,
        MEM_WAIT = 2'b10
    } hc_state_e;

endpackage

// File: rtl/hazard_wait_timer.sv
// Counts frozen cycles of one data-memory access; expired_o rises once the
// count reaches MAX_WAIT and the counter holds there until reloaded.
module hazard_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int W = $clog2(MAX_WAIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired_o = (cnt_q >= W'(MAX_WAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(1);
        end else if (inc_i && !expired_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: owns stage write enables, flushes and PC enable, resolving
// load-use stalls, control redirects and variable-latency memory freezes.
module hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_we,
    input  logic             ex_mem_read,
    input  logic [1:0]       ex_jump_t,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    hc_state_e        state_q, state_d;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_q;

    logic redirect, load_use, mem_block;
    logic run_rules, timer_load, timer_inc, timer_expired, timeout_set;
    logic [4:0] we_c;     // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0] flush_c;  // {if_id, id_ex}

    assign redirect  = ex_branch_taken | (ex_jump_t != NO_JUMP);
    assign load_use  = ex_mem_read & ex_reg_we & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign mem_block = mem_req & ~mem_ready;

    hazard_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk_i     (clk),
        .rst_ni    (rst),
        .load_i    (timer_load),
        .inc_i     (timer_inc),
        .expired_o (timer_expired)
    );

    // Enables are decoded from the current state and inputs so a hazard is
    // acted on in the very cycle it is seen.
    always_comb begin
        we_c        = 5'b00000;
        flush_c     = 2'b00;
        state_d     = state_q;
        run_rules   = 1'b0;
        timer_load  = 1'b0;
        timer_inc   = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            INIT: begin
                flush_c = 2'b11;
                state_d = RUN;
            end
            RUN: begin
                if (mem_block) begin
                    state_d    = MEM_WAIT;
                    timer_load = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_block) begin
                    run_rules = 1'b1;
                    state_d   = RUN;
                end else if (timer_expired) begin
                    timeout_set = 1'b1;
                    run_rules   = 1'b1;
                    state_d     = RUN;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: begin
                flush_c = 2'b11;
                state_d = INIT;
            end
        endcase
        // Redirect outranks load-use: the dependent instruction is killed anyway.
        if (run_rules) begin
            if (redirect) begin
                we_c    = 5'b11111;
                flush_c = 2'b11;
            end else if (load_use) begin
                we_c    = 5'b00111;
                flush_c = 2'b01;
            end else begin
                we_c    = 5'b11111;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= INIT;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q <= state_d;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            if (!we_c[4] && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = we_c;
    assign {if_id_flush, id_ex_flush} = flush_c;
    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_q;
    assign state       = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: a cycle model pushes expected outputs to a queue
// as stimulus is applied; the DUT response is popped and compared each cycle.
module tb_hazard_controller;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int SAT      = 15;

    localparam logic [1:0] S_INIT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_WAIT = 2'b10;
    localparam logic [1:0] J_NO   = 2'b00;
    localparam logic [1:0] J_JAL  = 2'b01;
    localparam logic [1:0] J_JALR = 2'b10;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_reg_we, ex_mem_read;
    logic [1:0] ex_jump_t;
    logic ex_branch_taken, mem_req, mem_ready;
    logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_flush, id_ex_flush, mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0] state;

    logic [13:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] m_state, nx_state;
    int m_wcnt, nx_wcnt, m_stall, nx_stall;
    logic m_timeout, nx_timeout;

    always #5 clk = ~clk;

    hazard_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read),
        .ex_jump_t(ex_jump_t), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_reg_we = 1'b0; ex_mem_read = 1'b0;
        ex_jump_t = J_NO; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_reg_we = 1'b1; ex_rd = rd;
        id_rs2 = rd; id_use_rs2 = 1'b1;
    endtask

    // Reference behaviour for one cycle with the inputs currently applied.
    task automatic model_eval();
        logic redir, lu, mb, run;
        logic [4:0] we;
        logic [1:0] fl;
        if (!rst) begin
            m_state = S_INIT; m_wcnt = 0; m_timeout = 1'b0; m_stall = 0;
        end
        redir = ex_branch_taken || (ex_jump_t != J_NO);
        lu = ex_mem_read && ex_reg_we && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        mb = mem_req && !mem_ready;
        we = 5'b00000; fl = 2'b00; run = 1'b0;
        nx_state = m_state; nx_wcnt = m_wcnt; nx_timeout = m_timeout;
        if (m_state == S_INIT) begin
            fl = 2'b11; nx_state = S_RUN;
        end else if (m_state == S_RUN) begin
            if (mb) begin nx_state = S_WAIT; nx_wcnt = 1; end
            else run = 1'b1;
        end else begin
            if (!mb) begin run = 1'b1; nx_state = S_RUN; end
            else if (m_wcnt == MAX_WAIT) begin nx_timeout = 1'b1; run = 1'b1; nx_state = S_RUN; end
            else nx_wcnt = m_wcnt + 1;
        end
        if (run) begin
            if (redir) begin we = 5'b11111; fl = 2'b11; end
            else if (lu) begin we = 5'b00111; fl = 2'b01; end
            else we = 5'b11111;
        end
        exp_q.push_back({m_state, we, fl, m_timeout, 4'(m_stall)});
        nx_stall = (!we[4] && m_stall < SAT) ? m_stall + 1 : m_stall;
        if (!rst) begin
            nx_state = S_INIT; nx_wcnt = 0; nx_timeout = 1'b0; nx_stall = 0;
        end
    endtask

    // Inputs are applied just after a falling edge; outputs are sampled 2ns later.
    task automatic cycle(input string tag);
        logic [13:0] d;
        model_eval();
        #2;
        d = exp_q.pop_front();
        check({tag, ".state"}, 32'(state), 32'(d[13:12]));
        check({tag, ".we"}, 32'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}), 32'(d[11:7]));
        check({tag, ".flush"}, 32'({if_id_flush, id_ex_flush}), 32'(d[6:5]));
        check({tag, ".timeout"}, 32'(mem_timeout), 32'(d[4]));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(d[3:0]));
        m_state = nx_state; m_wcnt = nx_wcnt; m_timeout = nx_timeout; m_stall = nx_stall;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        m_state = S_INIT; m_wcnt = 0; m_timeout = 1'b0; m_stall = 0;
        @(negedge clk);
        cycle("reset_a");
        cycle("reset_b");

        rst = 1'b1;
        cycle("init");
        cycle("run");

        set_load_use(5'd5);
        cycle("load_use");
        idle();
        cycle("load_use_after");
        set_load_use(5'd0);
        cycle("load_use_x0");
        idle();
        ex_mem_read = 1'b1; ex_reg_we = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        cycle("load_use_rs1");
        id_use_rs1 = 1'b0;
        cycle("no_use_rs1");
        idle();

        set_load_use(5'd9);
        ex_jump_t = J_JALR;
        cycle("jalr_over_lu");
        idle();
        ex_branch_taken = 1'b1;
        cycle("branch");
        idle();
        ex_jump_t = J_JAL;
        cycle("jal");
        idle();

        mem_req = 1'b1;
        repeat (3) cycle("mem_wait");
        mem_ready = 1'b1;
        cycle("mem_ready");
        idle();
        cycle("mem_after");

        mem_req = 1'b1; ex_jump_t = J_JAL;
        repeat (2) cycle("wait_redir");
        mem_ready = 1'b1;
        cycle("redir_release");
        idle();

        mem_req = 1'b1;
        repeat (6) cycle("timeout");
        idle();
        repeat (2) cycle("timeout_sticky");

        mem_req = 1'b1;
        repeat (20) cycle("saturate");
        check("stall_saturated", 32'(stall_cnt), SAT);

        rst = 1'b0;
        cycle("abort_reset");
        rst = 1'b1;
        idle();
        cycle("abort_init");
        cycle("abort_run");

        repeat (60) begin
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            ex_rd = 5'($urandom_range(0, 3));
            ex_reg_we = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_jump_t = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 2)) : J_NO;
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req = ($urandom_range(0, 2) == 0);
            mem_ready = 1'($urandom_range(0, 1));
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage RISC-V core. It owns every stage-register write enable and flush, and the PC write enable.
- Resolves three conditions the forwarding mux selects cannot cover:
  - load-use hazards, by stalling one cycle;
  - control redirects from taken branches, JAL and JALR, by flushing;
  - variable-latency data-memory accesses, by freezing the pipeline with a timeout.
- Sits beside the DataForwarding selector. Forwarding resolves everything else.

Parameters:
- MAX_WAIT, 16, maximum cycles the pipeline stays frozen on one data-memory access before a forced release.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  the ID instruction reads rs1
- id_use_rs2  in  1  the ID instruction reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_reg_we  in  1  the EX instruction writes the register file
- ex_mem_read  in  1  the EX instruction is a load
- ex_jump_t  in  2  EX jump type: NO_JUMP=00, JAL=01, JAL_R=10
- ex_branch_taken  in  1  the EX conditional branch resolved taken
- mem_req  in  1  the MEM stage is issuing a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_we  out  1  PC register write enable
- if_id_we  out  1  IF/ID register write enable
- id_ex_we  out  1  ID/EX register write enable
- ex_mem_we  out  1  EX/MEM register write enable
- mem_wb_we  out  1  MEM/WB register write enable
- if_id_flush  out  1  load a NOP into IF/ID
- id_ex_flush  out  1  load a bubble into ID/EX
- mem_timeout  out  1  sticky error: an access exceeded MAX_WAIT
- stall_cnt  out  CNT_W  number of cycles with pc_we=0, saturating
- state  out  2  current FSM state, for debug

Behaviour:
- Derived terms (combinational):
  - redirect = ex_branch_taken | (ex_jump_t != NO_JUMP)
  - load_use = ex_mem_read & ex_reg_we & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))
  - mem_block = mem_req & ~mem_ready
- FSM states: INIT=00, RUN=01, MEM_WAIT=10.
- Reset (rst=0, asynchronous):
  - state goes to INIT; the wait counter, mem_timeout and stall_cnt go to 0.
- INIT (exactly one cycle after reset release):
  - all five write enables are 0; if_id_flush=1, id_ex_flush=1.
  - Next state is RUN, unconditionally.
- RUN, priority from highest to lowest:
  1. mem_block: all write enables 0, no flushes. Next state MEM_WAIT; the wait counter loads 1.
  2. redirect: all write enables 1; if_id_flush=1 and id_ex_flush=1 for this cycle only. PC takes the target, supplied externally.
  3. load_use: pc_we=0, if_id_we=0, id_ex_flush=1; the other enables are 1. This lasts exactly one cycle. The load then sits in MEM and forwarding supplies it.
  4. Otherwise: all enables 1, no flushes.
- Redirect and load_use in the same cycle: redirect wins, because the dependent instruction is being killed anyway.
- MEM_WAIT:
  - All enables are 0 and there are no flushes while mem_block holds and the counter is below MAX_WAIT; the counter increments each cycle.
  - mem_ready=1: the cycle is evaluated with RUN rules (mem_block is now 0) and the next state is RUN. A redirect or load_use held in EX/ID during the freeze is therefore applied in the release cycle.
  - Counter equals MAX_WAIT with mem_ready still 0: set mem_timeout. This cycle is evaluated with RUN rules, ignoring mem_block, and the next state is RUN.
  - mem_timeout clears only on reset.
- stall_cnt increments in any cycle where pc_we=0, including INIT. It saturates at 2^CNT_W-1 and does not wrap.
- rd=x0 never triggers load_use.
- A mid-freeze reset aborts the wait immediately; outputs take their INIT values asynchronously.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the jump-type constants NO_JUMP, JAL, JAL_R, shared with DataForwarding;
  - the FSM state encodings INIT/RUN/MEM_WAIT.
- One sub-module, hazard_wait_timer: the MAX_WAIT counter with load, increment and an expired flag.

Test Plan:
- Reset release: rst low, then high at cycle 0. Cycle 0 shows INIT, all enables 0, both flushes 1, stall_cnt then 1. Cycle 1 is RUN with all enables 1.
- Load-use: ex_mem_read=1, ex_reg_we=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle. Response: pc_we=0, if_id_we=0, id_ex_flush=1 for exactly one cycle. The same stimulus with ex_rd=0 gives no stall.
- Redirect: ex_jump_t=JAL_R together with a load_use match. Response: if_id_flush=1, id_ex_flush=1, pc_we=1, no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1. Response: the freeze lasts 3 cycles (state=MEM_WAIT), all enables return to 1 on the ready cycle, mem_timeout stays 0.
- Timeout: MAX_WAIT=4 with mem_ready held at 0. Response: release after 4 frozen cycles, mem_timeout=1 and sticky until rst.
- Saturation: CNT_W=4 with 20 stall cycles. Response: stall_cnt holds at 15.
